reg_write_tracer: RTL and testbench
===================================

# reg_write_tracer

Passive trace unit on the register-file write port of `Simple_Single_CPU`. It captures every architectural register write as an (address, data, cycle-stamp) record in a small FIFO. It drains the records to a consumer over a valid/ready handshake. Simulation benches and an on-chip dump path use it to check write order and timing, not only the final register contents.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DATA_W`, 32: register data width.
- `CYC_W`, 16: cycle-stamp width.
- `DROP_R0`, 1: when 1, writes to r0 are not recorded.

Ports:
- `clk_i`  in  1  system clock, rising edge.
- `rst_i`  in  1  reset. Asynchronous, active-low.
- `clear_i`  in  1  synchronous flush of the FIFO, cycle counter, drop counter and overflow flag.
- `wr_en_i`  in  1  CPU RegWrite strobe.
- `wr_addr_i`  in  5  destination register.
- `wr_data_i`  in  DATA_W  write data.
- `out_valid_o`  out  1  head record available.
- `out_ready_i`  in  1  consumer accepts the head record.
- `out_addr_o`  out  5  head record address.
- `out_data_o`  out  DATA_W  head record data.
- `out_cycle_o`  out  CYC_W  head record cycle stamp.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow_o`  out  1  sticky: at least one record was dropped because the FIFO was full.
- `drop_cnt_o`  out  8  dropped-record count; saturates at 255.

## Operation
- Cycle counter `cyc`:
  - 0 after reset.
  - +1 every clock while not in reset.
  - Wraps modulo 2^CYC_W.
- Qualified push: `wr_en_i && !(DROP_R0 && wr_addr_i==0)`. Pushed record is {wr_addr_i, wr_data_i, cyc value in the same cycle}.
- Pop: `out_valid_o && out_ready_i`.
- FIFO is show-ahead. Head fields are driven from storage and are stable while `out_valid_o && !out_ready_i`.
- Full, no pop: the qualified push is discarded. `overflow_o` is set; `drop_cnt_o` increments and saturates at 255.
- Full, pop in the same cycle: the push is accepted and occupancy stays at DEPTH.
- Empty with a push: the record is not bypassed. `out_valid_o` rises the next cycle.
- Pointers are log2(DEPTH) bits plus a wrap bit. Full means equal indices with differing wrap bits.
- `clear_i`:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: FIFO is empty, `cyc`=0, overflow=0, drop count=0.
  - A write in the clear cycle is lost.
- `out_*` data fields are don't-care while `out_valid_o`=0. The implementation holds the last head values.

## Timing
- Reset values: `out_valid_o`=0, `count_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `out_addr_o`=0, `out_data_o`=0, `out_cycle_o`=0; internal `cyc`=0 and both pointers 0.
- Reset asserted mid-operation: all stored records are discarded immediately, asynchronously.
- Latency from qualified push at edge N to the record at the head (FIFO empty): `out_valid_o`=1 after edge N.
- Throughput: one push and one pop per cycle, sustained.
- `count_o` updates on the same edge as the push/pop. Simultaneous push and pop leaves it unchanged.
- No combinational path from `out_ready_i` to any output.

## Structure
- Package `lab3_trace_pkg`:
  - `REG_ADDR_W`=5.
  - Default `DATA_W` and `CYC_W`.
  - Packed struct `trace_rec_t` {addr, data, cycle}.
- Sub-module `trace_fifo`: generic show-ahead synchronous FIFO of `trace_rec_t`, with push/pop/clear and full/empty/count outputs.
- Top level holds the cycle counter, r0 filter, overflow/drop logic and port unpacking.

## Test plan
- Reset release, then writes r1=5 at cyc 3, r2=7 at cyc 4, `out_ready_i`=1 → records (1,5,3) then (2,7,4), each valid one cycle after its write.
- DROP_R0=1, write r0=9 then r3=1 → only (3,1,·) appears; `count_o` never exceeds 1.
- `out_ready_i`=0, 17 consecutive writes to r4 with data 0..16, DEPTH=16 → `count_o`=16, `overflow_o`=1, `drop_cnt_o`=1; draining yields data 0..15 in order.
- Full FIFO with push and pop in the same cycle → occupancy stays 16, no drop, new record arrives last.
- Assert `rst_i`=0 for half a cycle mid-stream with 5 entries queued → `out_valid_o`=0 and `count_o`=0 immediately; next write is stamped from `cyc`=0 after release.
- `clear_i` pulse with 3 entries queued and a simultaneous write → next cycle `count_o`=0, overflow 0, and the simultaneous write is absent.

Source files
------------

// File: rtl/lab3_trace_pkg.sv
// Shared types and widths for the register-write trace unit.
//   REG_ADDR_W  : register-file address width
//   DEF_DATA_W  : default register data width
//   DEF_CYC_W   : default cycle-stamp width
//   trace_rec_t : one captured write {addr, data, cycle} at default widths
package lab3_trace_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CYC_W  = 16;
    localparam int unsigned DROP_CNT_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_CYC_W-1:0]  cycle;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic show-ahead synchronous FIFO with a registered head record.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   clear          : synchronous flush, wins over push/pop
//   push, push_rec : write request and record
//   pop            : consume head (ignored while empty)
//   head, valid    : registered head record and its valid flag
//   full_c         : full flag decoded from the pointers
//   count          : registered occupancy
module trace_fifo
    import lab3_trace_pkg::*;
#(
    parameter int unsigned  DEPTH = 16,
    parameter type          rec_t = trace_rec_t,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  rec_t          push_rec,
    input  logic          pop,
    output rec_t          head,
    output logic          valid,
    output logic          full_c,
    output logic [CW-1:0] count
);

    rec_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    rec_t          head_q, head_d;
    logic          pop_ok;
    logic          push_ok;
    logic          mem_we;

    // Full: same slot index, opposite lap.
    assign full_c = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Next-state: pointers, occupancy and the head record as it will look after the edge.
    always_comb begin
        pop_ok   = pop && valid_q;
        push_ok  = push && (!full_c || pop_ok);
        mem_we   = push_ok && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        head_d   = head_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
            rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
            count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
            valid_d  = (count_d != '0);
            // Nothing left after the pop: the incoming record (if any) becomes head,
            // otherwise keep the last head values.
            if (count_q == CW'(pop_ok)) begin
                if (push_ok) begin
                    head_d = push_rec;
                end
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Storage array; only slots behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/reg_write_tracer.sv
// Passive tracer for the register-file write port: records every qualified
// write as {addr, data, cycle stamp} and drains them over valid/ready.
// Ports:
//   clk_i, rst_i         : clock, async active-low reset
//   clear_i              : flush FIFO, cycle counter, overflow and drop count
//   wr_en_i/addr/data    : CPU register write port being observed
//   out_valid_o/ready_i  : record handshake
//   out_addr/data/cycle  : head record fields
//   count_o              : occupancy
//   overflow_o           : sticky, a record was lost to a full FIFO
//   drop_cnt_o           : lost-record count, saturating
module reg_write_tracer
    import lab3_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CYC_W   = DEF_CYC_W,
    parameter bit          DROP_R0 = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    wr_en_i,
    input  logic [REG_ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [REG_ADDR_W-1:0]   out_addr_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [CYC_W-1:0]        out_cycle_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [CYC_W-1:0]      cycle;
    } rec_t;

    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  qual_push;
    logic                  pop;
    logic                  drop;
    rec_t                  push_rec;
    rec_t                  head;
    logic                  fifo_valid;
    logic                  fifo_full_c;
    logic [CNT_W-1:0]      fifo_count;

    // Write qualification, stamping and overflow bookkeeping.
    always_comb begin
        qual_push      = wr_en_i && !(DROP_R0 && (wr_addr_i == '0));
        pop            = fifo_valid && out_ready_i;
        drop           = qual_push && fifo_full_c && !pop;
        push_rec.addr  = wr_addr_i;
        push_rec.data  = wr_data_i;
        push_rec.cycle = cyc_q;
        cyc_d          = cyc_q + CYC_W'(1);
        ovf_d          = ovf_q;
        drop_d         = drop_q;
        if (clear_i) begin
            cyc_d  = '0;
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .clear    (clear_i),
        .push     (qual_push),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head),
        .valid    (fifo_valid),
        .full_c   (fifo_full_c),
        .count    (fifo_count)
    );

    assign out_valid_o = fifo_valid;
    assign out_addr_o  = head.addr;
    assign out_data_o  = head.data;
    assign out_cycle_o = head.cycle;
    assign count_o     = fifo_count;
    assign overflow_o  = ovf_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_reg_write_tracer.sv
// Self-checking bench for reg_write_tracer (default parameters: DEPTH=16,
// DATA_W=32, CYC_W=16, DROP_R0=1). A reference queue predicts the record
// stream; consumed head records are also logged for fixed-value checks.
module tb_reg_write_tracer;
    import lab3_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [4:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [4:0]  out_addr_o;
    logic [31:0] out_data_o;
    logic [15:0] out_cycle_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic [7:0]  drop_cnt_o;

    reg_write_tracer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_addr_o  (out_addr_o),
        .out_data_o  (out_data_o),
        .out_cycle_o (out_cycle_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: expected FIFO contents and status.
    trace_rec_t  exp_q[$];
    trace_rec_t  got_q[$];
    logic [15:0] m_cyc  = '0;
    logic        m_ovf  = 1'b0;
    logic [7:0]  m_drop = '0;
    int          max_cnt = 0;

    function automatic trace_rec_t got_at(input int i);
        trace_rec_t r;
        r = '0;
        if (i < got_q.size()) r = got_q[i];
        return r;
    endfunction

    always @(negedge rst_i) begin
        exp_q.delete();
        m_cyc  = '0;
        m_ovf  = 1'b0;
        m_drop = '0;
    end

    // Compare against the model mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (rst_i) begin
            trace_rec_t obs;
            logic       do_pop;
            obs = '{addr: out_addr_o, data: out_data_o, cycle: out_cycle_o};
            check("valid", out_valid_o, exp_q.size() != 0);
            check("count", count_o, exp_q.size());
            check("overflow", overflow_o, m_ovf);
            check("drop_cnt", drop_cnt_o, m_drop);
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
            if (exp_q.size() != 0) check("head", obs, exp_q[0]);
            if (out_valid_o && out_ready_i && !clear_i) got_q.push_back(obs);
            if (clear_i) begin
                exp_q.delete();
                m_cyc  = '0;
                m_ovf  = 1'b0;
                m_drop = '0;
            end else begin
                do_pop = (exp_q.size() != 0) && out_ready_i;
                if (do_pop) void'(exp_q.pop_front());
                if (wr_en_i && wr_addr_i != 5'd0) begin
                    if (exp_q.size() < 16) begin
                        exp_q.push_back('{addr: wr_addr_i, data: wr_data_i, cycle: m_cyc});
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                    end
                end
                m_cyc = m_cyc + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    initial begin
        trace_rec_t r;
        // Reset values
        repeat (3) tick();
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_count", count_o, 5'd0);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_drop", drop_cnt_o, 8'd0);
        check("rst_addr", out_addr_o, 5'd0);
        check("rst_data", out_data_o, 32'd0);
        check("rst_cycle", out_cycle_o, 16'd0);
        rst_i       = 1'b1;
        out_ready_i = 1'b1;

        // Basic capture: r1=5 at cyc 3, r2=7 at cyc 4
        repeat (3) tick();
        wr(5'd1, 32'd5);
        check("t1_valid0", out_valid_o, 1'b1);
        check("t1_head0", {out_addr_o, out_data_o, out_cycle_o}, {5'd1, 32'd5, 16'd3});
        wr(5'd2, 32'd7);
        check("t1_head1", {out_addr_o, out_data_o, out_cycle_o}, {5'd2, 32'd7, 16'd4});
        repeat (2) tick();
        check("t1_n", got_q.size(), 2);
        check("t1_rec0", got_at(0), {5'd1, 32'd5, 16'd3});
        check("t1_rec1", got_at(1), {5'd2, 32'd7, 16'd4});

        // r0 filter
        got_q.delete();
        max_cnt = 0;
        wr(5'd0, 32'd9);
        check("t2_r0_count", count_o, 5'd0);
        wr(5'd3, 32'd1);
        repeat (3) tick();
        check("t2_max", max_cnt, 1);
        check("t2_n", got_q.size(), 1);
        r = got_at(0);
        check("t2_rec", {r.addr, r.data}, {5'd3, 32'd1});

        // Overflow with a stalled consumer
        out_ready_i = 1'b0;
        clear_i     = 1'b1;
        tick();
        clear_i = 1'b0;
        got_q.delete();
        for (int i = 0; i < 17; i++) wr(5'd4, 32'(i));
        check("t3_count", count_o, 5'd16);
        check("t3_ovf", overflow_o, 1'b1);
        check("t3_drop", drop_cnt_o, 8'd1);
        check("t3_head", out_data_o, 32'd0);

        // Full FIFO, push and pop together
        out_ready_i = 1'b1;
        wr(5'd5, 32'd99);
        check("t4_count", count_o, 5'd16);
        check("t4_drop", drop_cnt_o, 8'd1);
        repeat (17) tick();
        check("t4_n", got_q.size(), 17);
        for (int i = 0; i < 16; i++) begin
            r = got_at(i);
            check($sformatf("t3_drain%0d", i), {r.addr, r.data}, {5'd4, 32'(i)});
        end
        r = got_at(16);
        check("t4_last", {r.addr, r.data}, {5'd5, 32'd99});
        check("t4_empty", out_valid_o, 1'b0);

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) wr(5'd6, 32'(10 + i));
        check("t5_pre_count", count_o, 5'd5);
        #1 rst_i = 1'b0;
        #1;
        check("t5_rst_valid", out_valid_o, 1'b0);
        check("t5_rst_count", count_o, 5'd0);
        check("t5_rst_ovf", overflow_o, 1'b0);
        #1 rst_i = 1'b1;
        out_ready_i = 1'b1;
        wr(5'd7, 32'h77);
        check("t5_valid", out_valid_o, 1'b1);
        check("t5_head", {out_addr_o, out_data_o, out_cycle_o}, {5'd7, 32'h77, 16'd0});
        check("t5_count", count_o, 5'd1);
        tick();

        // Clear with entries queued and a write in the same cycle
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) wr(5'd9, 32'(i));
        check("t6_pre_count", count_o, 5'd3);
        clear_i   = 1'b1;
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd10;
        wr_data_i = 32'hAA;
        tick();
        clear_i = 1'b0;
        wr_en_i = 1'b0;
        check("t6_count", count_o, 5'd0);
        check("t6_valid", out_valid_o, 1'b0);
        check("t6_ovf", overflow_o, 1'b0);
        got_q.delete();
        out_ready_i = 1'b1;
        wr(5'd11, 32'd1);
        repeat (2) tick();
        check("t6_n", got_q.size(), 1);
        check("t6_rec", got_at(0), {5'd11, 32'd1, 16'd0});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
